mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single data-memory port, shared between the load queue (speculative loads) and the store queue (committed-store drain). It grants one requester at a time and drives the memory request handshake. It tracks one outstanding load and returns its data with the load tag to the memory unit, which broadcasts it on the CDB. It sits between the memory unit's LDQ/STQ and the `mem_if` port.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single data-memory port arbiter for load and store queues
//
// Grants the shared memory port to either the load queue or the store queue,
// drives the request handshake, tracks one outstanding load and returns its
// result with the load tag.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   flush                kills speculative load traffic
//   ld_req_*             load request from the LDQ (valid/ready, addr, tag)
//   st_req_*             committed store from the STQ (valid/ready, addr, data, urgent)
//   mem_req_*            request to memory (valid/ready, we, addr, wdata)
//   mem_rsp_*            read data from memory
//   ld_rsp_*             load result pulse (valid, tag, data)
//   busy                 a transaction is held
//   protocol_err         sticky: read data arrived when no load was waiting
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [TAG_WIDTH-1:0] ld_tag,
  input  logic                 st_req_valid,
  output logic                 st_req_ready,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  input  logic                 st_urgent,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_we,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_wdata,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_rdata,
  output logic                 ld_rsp_valid,
  output logic [TAG_WIDTH-1:0] ld_rsp_tag,
  output logic [DATA_W-1:0]    ld_rsp_data,
  output logic                 busy,
  output logic                 protocol_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LD} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t               state_q, state_d;
  logic [3:0]           starve_cnt_q, starve_cnt_d;
  logic                 killed_q, killed_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 perr_q, perr_d;

  logic load_elig;
  logic st_win;
  logic ld_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      killed_q     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      killed_q     <= killed_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_data_q   <= rsp_data_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    killed_d     = killed_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    rsp_valid_d  = 1'b0;
    rsp_tag_d    = rsp_tag_q;
    rsp_data_d   = rsp_data_q;
    perr_d       = perr_q | (mem_rsp_valid && (state_q != WAIT_LD));

    // Stores win when urgent, when loads have had their quota, or when no
    // load can go; grants happen only with the port idle.
    load_elig = ld_req_valid && !flush;
    st_win    = (state_q == IDLE) && st_req_valid &&
                (st_urgent || (starve_cnt_q == STARVE_LIM) || !load_elig);
    ld_win    = (state_q == IDLE) && load_elig && !st_win;

    case (state_q)
      IDLE: begin
        if (st_win) begin
          we_d    = 1'b1;
          addr_d  = st_addr;
          wdata_d = st_data;
          state_d = REQ;
        end else if (ld_win) begin
          we_d    = 1'b0;
          addr_d  = ld_addr;
          tag_d   = ld_tag;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = we_q ? IDLE : WAIT_LD;
      end
      WAIT_LD: begin
        if (mem_rsp_valid) begin
          state_d     = IDLE;
          // A flush coinciding with the response also suppresses it.
          rsp_valid_d = !killed_q && !flush;
          rsp_tag_d   = tag_q;
          rsp_data_d  = mem_rsp_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (st_win || !st_req_valid) begin
      starve_cnt_d = '0;
    end else if (ld_win && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Only a held load can be killed; the mark lives until the port is idle.
    if (state_d == IDLE) begin
      killed_d = 1'b0;
    end else if (flush && (state_q != IDLE) && !we_q) begin
      killed_d = 1'b1;
    end
  end

  // Ready is combinational, so it must be masked while reset holds IDLE.
  assign ld_req_ready  = ld_win && !rst;
  assign st_req_ready  = st_win && !rst;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign ld_rsp_valid  = rsp_valid_q;
  assign ld_rsp_tag    = rsp_tag_q;
  assign ld_rsp_data   = rsp_data_q;
  assign busy          = (state_q != IDLE);
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [31:0] ld_addr;
  logic [5:0]  ld_tag;
  logic        st_req_valid;
  logic        st_req_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_urgent;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        ld_rsp_valid;
  logic [5:0]  ld_rsp_tag;
  logic [31:0] ld_rsp_data;
  logic        busy;
  logic        protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TAG_WIDTH(6), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_addr(ld_addr), .ld_tag(ld_tag),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_addr(st_addr), .st_data(st_data), .st_urgent(st_urgent),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_tag(ld_rsp_tag),
    .ld_rsp_data(ld_rsp_data), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Full load: grant, accepted immediately, response two cycles later.
  task automatic do_load(input logic [31:0] addr, input logic [5:0] tag, input logic [31:0] data);
    step(); ld_req_valid = 1'b1; ld_addr = addr; ld_tag = tag; mem_req_ready = 1'b1; #1;
    check_val("ld_grant", ld_req_ready, 1);
    check_val("ld_grant_st_rdy", st_req_ready, 0);
    step(); ld_req_valid = 1'b0; #1;
    check_val("ld_req_valid", mem_req_valid, 1);
    check_val("ld_req_we", mem_req_we, 0);
    check_val("ld_req_addr", mem_req_addr, addr);
    step(); mem_rsp_valid = 1'b1; mem_rsp_rdata = data; #1;
    check_val("ld_wait_valid", mem_req_valid, 0);
    check_val("ld_wait_busy", busy, 1);
    step(); mem_rsp_valid = 1'b0; #1;
    check_val("ld_rsp_valid", ld_rsp_valid, 1);
    check_val("ld_rsp_tag", ld_rsp_tag, tag);
    check_val("ld_rsp_data", ld_rsp_data, data);
    check_val("ld_done_busy", busy, 0);
    step(); #1;
    check_val("ld_rsp_pulse", ld_rsp_valid, 0);
  endtask

  initial begin
    logic grants[6];
    logic exp_grants[6];
    int   ng;
    logic pend;
    logic chk_cnt;

    rst = 1'b1; flush = 0; ld_req_valid = 1'b1; ld_addr = 0; ld_tag = 0;
    st_req_valid = 1'b1; st_addr = 0; st_data = 0; st_urgent = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    repeat (2) step();
    #1;
    check_val("rst_ld_ready", ld_req_ready, 0);
    check_val("rst_st_ready", st_req_ready, 0);
    check_val("rst_req_valid", mem_req_valid, 0);
    check_val("rst_req_we", mem_req_we, 0);
    check_val("rst_req_addr", mem_req_addr, 0);
    check_val("rst_rsp_valid", ld_rsp_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_perr", protocol_err, 0);
    ld_req_valid = 0; st_req_valid = 0;
    step(); rst = 1'b0;

    // Load only
    do_load(32'h100, 6'd5, 32'hDEADBEEF);

    // Store with three cycles of backpressure
    step(); st_req_valid = 1'b1; st_addr = 32'h200; st_data = 32'hA5A5A5A5; mem_req_ready = 0; #1;
    check_val("st_grant", st_req_ready, 1);
    check_val("st_grant_ld_rdy", ld_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(); st_req_valid = 0; mem_req_ready = (i == 3); #1;
      check_val("st_hold_valid", mem_req_valid, 1);
      check_val("st_hold_we", mem_req_we, 1);
      check_val("st_hold_addr", mem_req_addr, 32'h200);
      check_val("st_hold_data", mem_req_wdata, 32'hA5A5A5A5);
    end
    step(); #1;
    check_val("st_done_busy", busy, 0);
    check_val("st_done_valid", mem_req_valid, 0);
    check_val("st_no_ld_rsp", ld_rsp_valid, 0);

    // Starvation: both valid, expect L,L,L,L,S,L
    exp_grants = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ng = 0; pend = 0; chk_cnt = 0;
    step(); ld_req_valid = 1; ld_addr = 32'h500; ld_tag = 6'd1;
    st_req_valid = 1; st_addr = 32'h400; st_data = 32'h11; mem_req_ready = 1; mem_rsp_rdata = 32'h77;
    #1;
    for (int cyc = 0; cyc < 80 && ng < 6; cyc++) begin
      if (cyc != 0) begin
        step(); mem_rsp_valid = pend; #1;
      end
      pend = mem_req_valid && !mem_req_we;
      if (chk_cnt) begin
        check_val("starve_cleared", dut.starve_cnt_q, 0);
        chk_cnt = 0;
      end
      if (ld_req_ready || st_req_ready) begin
        grants[ng] = st_req_ready;
        if (st_req_ready) begin
          check_val("starve_at_max", dut.starve_cnt_q, 4);
          chk_cnt = 1;
        end
        ng++;
      end
    end
    check_val("starve_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) check_val($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
    for (int i = 0; i < 6; i++) begin
      step(); ld_req_valid = 0; st_req_valid = 0; mem_rsp_valid = pend; #1;
      pend = mem_req_valid && !mem_req_we;
    end
    step(); mem_rsp_valid = 0; #1;
    check_val("starve_drained", busy, 0);

    // Urgent store beats a waiting load
    step(); ld_req_valid = 1; st_req_valid = 1; st_urgent = 1; st_addr = 32'h600; #1;
    check_val("urg_st_ready", st_req_ready, 1);
    check_val("urg_ld_ready", ld_req_ready, 0);
    step(); ld_req_valid = 0; st_req_valid = 0; st_urgent = 0; #1;
    check_val("urg_we", mem_req_we, 1);
    step(); #1;
    check_val("urg_done", busy, 0);

    // Flush while waiting for load data
    step(); ld_req_valid = 1; ld_addr = 32'h300; ld_tag = 6'd9; #1;
    check_val("fl_grant", ld_req_ready, 1);
    step(); ld_req_valid = 0;
    step(); flush = 1;
    step(); flush = 0;
    step(); mem_rsp_valid = 1; mem_rsp_rdata = 32'h55;
    step(); mem_rsp_valid = 0; #1;
    check_val("fl_no_rsp", ld_rsp_valid, 0);
    check_val("fl_idle", busy, 0);
    check_val("fl_no_perr", protocol_err, 0);
    do_load(32'h340, 6'd3, 32'h12345678);

    // Flush in the same cycle as the response
    step(); ld_req_valid = 1; ld_tag = 6'd7; #1;
    check_val("flr_grant", ld_req_ready, 1);
    step(); ld_req_valid = 0;
    step(); mem_rsp_valid = 1; flush = 1;
    step(); mem_rsp_valid = 0; flush = 0; #1;
    check_val("flr_no_rsp", ld_rsp_valid, 0);
    check_val("flr_idle", busy, 0);

    // Flush in IDLE blocks the load but not the store
    step(); ld_req_valid = 1; flush = 1; #1;
    check_val("fli_ld_blocked", ld_req_ready, 0);
    st_req_valid = 1; #1;
    check_val("fli_st_granted", st_req_ready, 1);
    step(); ld_req_valid = 0; st_req_valid = 0; flush = 0;
    step(); #1;
    check_val("fli_done", busy, 0);

    // Reset mid-transaction, then the late response is a protocol error
    step(); ld_req_valid = 1; mem_req_ready = 0;
    step(); ld_req_valid = 0; #1;
    check_val("rmt_req", mem_req_valid, 1);
    rst = 1; #1;
    check_val("rmt_dropped", mem_req_valid, 0);
    check_val("rmt_idle", busy, 0);
    step(); rst = 0; mem_req_ready = 1;
    step(); mem_rsp_valid = 1;
    step(); mem_rsp_valid = 0; #1;
    check_val("rmt_perr", protocol_err, 1);

    // Stray response in IDLE: sticky until reset
    step(); rst = 1;
    step(); rst = 0; #1;
    check_val("stray_pre", protocol_err, 0);
    step(); mem_rsp_valid = 1;
    step(); mem_rsp_valid = 0; #1;
    check_val("stray_set", protocol_err, 1);
    repeat (3) step();
    #1;
    check_val("stray_sticky", protocol_err, 1);
    rst = 1; #1;
    check_val("stray_cleared", protocol_err, 0);
    step(); rst = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
